// File: rtl/cpu_pkg.sv
// Shared CPU definitions: widths, reset vector, fetch FSM states and the
// RV base opcodes consumed by decode.
package cpu_pkg;

   localparam int unsigned XLEN     = 64;
   localparam logic [63:0] RESET_PC = 64'h0000_0000_8000_0000;
   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

   typedef enum logic [1:0] {
      REQ     = 2'd0,
      VALID   = 2'd1,
      DISCARD = 2'd2
   } fetch_state_t;

   localparam logic [6:0] OPC_LOAD   = 7'b000_0011;
   localparam logic [6:0] OPC_OP_IMM = 7'b001_0011;
   localparam logic [6:0] OPC_AUIPC  = 7'b001_0111;
   localparam logic [6:0] OPC_STORE  = 7'b010_0011;
   localparam logic [6:0] OPC_OP     = 7'b011_0011;
   localparam logic [6:0] OPC_LUI    = 7'b011_0111;
   localparam logic [6:0] OPC_BRANCH = 7'b110_0011;
   localparam logic [6:0] OPC_JALR   = 7'b110_0111;
   localparam logic [6:0] OPC_JAL    = 7'b110_1111;
   localparam logic [6:0] OPC_SYSTEM = 7'b111_0011;

endpackage

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues word fetches, buffers one
// response for decode and squashes wrong-path responses after a redirect.
module fetch_unit
   import cpu_pkg::*;
#(
   parameter int unsigned         XLEN     = cpu_pkg::XLEN,
   parameter logic [XLEN-1:0]     RESET_PC = XLEN'(cpu_pkg::RESET_PC)
) (
   input  logic            clk,
   input  logic            reset_n,
   output logic            ireq_valid,
   output logic [XLEN-1:0] ireq_addr,
   input  logic            iresp_data_ok,
   input  logic [31:0]     iresp_data,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_pc,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] out_pc,
   output logic [31:0]     out_instr,
   output logic            out_misalign
);

   fetch_state_t    state_q, state_d;
   logic [XLEN-1:0] pc_q, pc_d;
   logic [XLEN-1:0] req_addr_q, req_addr_d;
   logic [XLEN-1:0] out_pc_q, out_pc_d;
   logic [31:0]     out_instr_q, out_instr_d;
   logic            out_misalign_q, out_misalign_d;
   logic            parked_q, parked_d;
   logic            pc_aligned;

   assign pc_aligned = (pc_q[1:0] == 2'b00);

   // A misaligned PC in REQ never reaches the bus; it is reported once and
   // then parked until execute redirects.
   assign ireq_valid   = reset_n &&
                         (((state_q == REQ) && pc_aligned) || (state_q == DISCARD));
   assign ireq_addr    = req_addr_q;
   assign out_valid    = (state_q == VALID) && !redirect_valid;
   assign out_pc       = out_pc_q;
   assign out_instr    = out_instr_q;
   assign out_misalign = out_misalign_q;

   // Next-state logic: FSM transitions, PC update and output buffer capture.
   always_comb begin
      state_d        = state_q;
      pc_d           = pc_q;
      out_pc_d       = out_pc_q;
      out_instr_d    = out_instr_q;
      out_misalign_d = out_misalign_q;
      parked_d       = parked_q;

      unique case (state_q)
         REQ: begin
            if (redirect_valid) begin
               pc_d     = redirect_pc;
               parked_d = 1'b0;
               // Only an issued, still-unanswered request needs draining.
               if (pc_aligned && !iresp_data_ok) state_d = DISCARD;
               else                              state_d = REQ;
            end else if (!pc_aligned) begin
               if (!parked_q) begin
                  out_pc_d       = pc_q;
                  out_instr_d    = '0;
                  out_misalign_d = 1'b1;
                  state_d        = VALID;
               end
            end else if (iresp_data_ok) begin
               out_pc_d       = pc_q;
               out_instr_d    = iresp_data;
               out_misalign_d = 1'b0;
               pc_d           = pc_q + XLEN'(4);
               state_d        = VALID;
            end
         end
         VALID: begin
            if (redirect_valid) begin
               pc_d     = redirect_pc;
               parked_d = 1'b0;
               state_d  = REQ;
            end else if (out_ready) begin
               parked_d = out_misalign_q;
               state_d  = REQ;
            end
         end
         DISCARD: begin
            if (redirect_valid) begin
               pc_d     = redirect_pc;
               parked_d = 1'b0;
            end
            if (iresp_data_ok) state_d = REQ;
         end
         default: state_d = REQ;
      endcase

      // Bus address only follows pc when a fresh request phase begins, so it
      // stays on the in-flight address throughout DISCARD.
      req_addr_d = (state_d == REQ) ? pc_d : req_addr_q;
   end

   // State and datapath registers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q        <= REQ;
         pc_q           <= RESET_PC;
         req_addr_q     <= RESET_PC;
         out_pc_q       <= '0;
         out_instr_q    <= '0;
         out_misalign_q <= 1'b0;
         parked_q       <= 1'b0;
      end else begin
         state_q        <= state_d;
         pc_q           <= pc_d;
         req_addr_q     <= req_addr_d;
         out_pc_q       <= out_pc_d;
         out_instr_q    <= out_instr_d;
         out_misalign_q <= out_misalign_d;
         parked_q       <= parked_d;
      end
   end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: the bench plays instruction memory, pushes
// each response that must reach decode into a queue, and a monitor pops and
// compares on every decode handshake.
module tb_fetch_unit;

   localparam int unsigned XLEN = 64;
   localparam logic [63:0] RST_PC = 64'h0000_0000_8000_0000;

   logic            clk = 1'b0;
   logic            reset_n;
   logic            ireq_valid;
   logic [XLEN-1:0] ireq_addr;
   logic            iresp_data_ok;
   logic [31:0]     iresp_data;
   logic            redirect_valid;
   logic [XLEN-1:0] redirect_pc;
   logic            out_valid;
   logic            out_ready;
   logic [XLEN-1:0] out_pc;
   logic [31:0]     out_instr;
   logic            out_misalign;

   typedef struct {
      logic [63:0] pc;
      logic [31:0] instr;
      logic        mis;
   } exp_t;

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_errors = 0;

   fetch_unit #(.XLEN(64), .RESET_PC(RST_PC)) dut (
      .clk            (clk),
      .reset_n        (reset_n),
      .ireq_valid     (ireq_valid),
      .ireq_addr      (ireq_addr),
      .iresp_data_ok  (iresp_data_ok),
      .iresp_data     (iresp_data),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .out_pc         (out_pc),
      .out_instr      (out_instr),
      .out_misalign   (out_misalign)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // Advance to the next cycle: inputs change on the falling edge, pulses clear.
   task automatic cyc();
      @(negedge clk);
      iresp_data_ok  = 1'b0;
      redirect_valid = 1'b0;
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   // Wait for a request, check its address is held for lat cycles, then
   // answer in the lat-th cycle. present: response must reach decode.
   task automatic serve(input int lat, input logic [31:0] data,
                        input logic [63:0] exp_addr, input bit present);
      exp_t e;
      int n = 0;
      while (!ireq_valid && n < 20) begin
         cyc();
         n++;
      end
      check("req_seen", {63'd0, ireq_valid}, 64'd1);
      check("req_addr", ireq_addr, exp_addr);
      for (int i = 1; i < lat; i++) begin
         cyc();
         check("req_hold_valid", {63'd0, ireq_valid}, 64'd1);
         check("req_hold_addr", ireq_addr, exp_addr);
      end
      iresp_data_ok = 1'b1;
      iresp_data    = data;
      if (present) begin
         e.pc = exp_addr; e.instr = data; e.mis = 1'b0;
         exp_q.push_back(e);
      end
   endtask

   // Decode-side monitor: every accepted instruction must match the queue head.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         #3;
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               check("unexpected_out", out_pc, 64'hDEAD);
            end else begin
               e = exp_q.pop_front();
               check("out_pc", out_pc, e.pc);
               check("out_instr", {32'd0, out_instr}, {32'd0, e.instr});
               check("out_misalign", {63'd0, out_misalign}, {63'd0, e.mis});
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [63:0] hold_pc;
      logic [31:0] hold_instr;
      exp_t        e;

      reset_n = 1'b0; out_ready = 1'b0;
      iresp_data_ok = 1'b0; iresp_data = '0;
      redirect_valid = 1'b0; redirect_pc = '0;

      // Reset state
      repeat (3) cyc();
      check("rst_ireq_valid", {63'd0, ireq_valid}, 64'd0);
      check("rst_out_valid", {63'd0, out_valid}, 64'd0);
      check("rst_out_pc", out_pc, 64'd0);
      check("rst_out_instr", {32'd0, out_instr}, 64'd0);
      check("rst_out_misalign", {63'd0, out_misalign}, 64'd0);

      // First fetch after reset, 3-cycle memory latency
      @(negedge clk);
      reset_n = 1'b1;
      #1;
      check("first_req_valid", {63'd0, ireq_valid}, 64'd1);
      check("first_req_addr", ireq_addr, RST_PC);
      out_ready = 1'b1;
      serve(3, 32'h0000_0513, RST_PC, 1'b1);
      settle();
      check("dok_cycle_no_out", {63'd0, out_valid}, 64'd0);
      cyc();
      check("first_out_valid", {63'd0, out_valid}, 64'd1);
      check("valid_no_req", {63'd0, ireq_valid}, 64'd0);
      cyc();
      check("second_req_addr", ireq_addr, 64'h8000_0004);

      // Backpressure: held 5 cycles, no request until after acceptance
      out_ready = 1'b0;
      serve(1, 32'h0040_0093, 64'h8000_0004, 1'b1);
      cyc();
      check("bp_out_valid", {63'd0, out_valid}, 64'd1);
      hold_pc = out_pc; hold_instr = out_instr;
      for (int i = 0; i < 4; i++) begin
         cyc();
         check("bp_valid", {63'd0, out_valid}, 64'd1);
         check("bp_pc_stable", out_pc, 64'h8000_0004);
         check("bp_instr_stable", {32'd0, out_instr}, {32'd0, hold_instr});
         check("bp_no_req", {63'd0, ireq_valid}, 64'd0);
      end
      out_ready = 1'b1;
      settle();
      check("bp_accept_no_req", {63'd0, ireq_valid}, 64'd0);
      cyc();
      check("bp_next_req", {63'd0, ireq_valid}, 64'd1);
      check("bp_next_addr", ireq_addr, 64'h8000_0008);

      // Redirect while VALID with out_ready=1 squashes the transfer
      serve(2, 32'h1111_1113, 64'h8000_0008, 1'b0);
      cyc();
      redirect_valid = 1'b1; redirect_pc = 64'h8000_1000;
      settle();
      check("redir_valid_gated", {63'd0, out_valid}, 64'd0);
      cyc();
      serve(1, 32'h2222_2213, 64'h8000_1000, 1'b1);
      cyc();

      // Redirect with a request outstanding: old address held, response dropped
      cyc();
      check("disc_pre_addr", ireq_addr, 64'h8000_1004);
      redirect_valid = 1'b1; redirect_pc = 64'h8000_2000;
      cyc();
      check("disc_valid", {63'd0, ireq_valid}, 64'd1);
      check("disc_old_addr", ireq_addr, 64'h8000_1004);
      cyc();
      check("disc_old_addr2", ireq_addr, 64'h8000_1004);
      iresp_data_ok = 1'b1; iresp_data = 32'h3333_3313;
      cyc();
      check("disc_drop_out", {63'd0, out_valid}, 64'd0);
      check("disc_new_addr", ireq_addr, 64'h8000_2000);
      serve(2, 32'h4444_4413, 64'h8000_2000, 1'b1);
      cyc();

      // Redirect coincident with data_ok
      cyc();
      check("coinc_pre_addr", ireq_addr, 64'h8000_2004);
      iresp_data_ok = 1'b1; iresp_data = 32'h5555_5513;
      redirect_valid = 1'b1; redirect_pc = 64'h8000_3000;
      cyc();
      check("coinc_no_out", {63'd0, out_valid}, 64'd0);
      check("coinc_req_valid", {63'd0, ireq_valid}, 64'd1);
      check("coinc_req_addr", ireq_addr, 64'h8000_3000);
      serve(1, 32'h6666_6613, 64'h8000_3000, 1'b1);
      cyc();

      // Misaligned redirect (via DISCARD), then recovery
      cyc();
      redirect_valid = 1'b1; redirect_pc = 64'h8000_0002;
      cyc();
      check("mis_disc_addr", ireq_addr, 64'h8000_3004);
      iresp_data_ok = 1'b1; iresp_data = 32'h7777_7713;
      cyc();
      check("mis_no_req", {63'd0, ireq_valid}, 64'd0);
      check("mis_no_out_yet", {63'd0, out_valid}, 64'd0);
      e.pc = 64'h8000_0002; e.instr = 32'h0; e.mis = 1'b1;
      exp_q.push_back(e);
      cyc();
      check("mis_out_valid", {63'd0, out_valid}, 64'd1);
      check("mis_flag", {63'd0, out_misalign}, 64'd1);
      check("mis_instr_zero", {32'd0, out_instr}, 64'd0);
      check("mis_no_req2", {63'd0, ireq_valid}, 64'd0);
      for (int i = 0; i < 2; i++) begin
         cyc();
         check("parked_no_req", {63'd0, ireq_valid}, 64'd0);
         check("parked_no_out", {63'd0, out_valid}, 64'd0);
      end
      redirect_valid = 1'b1; redirect_pc = 64'h8000_0100;
      cyc();
      serve(1, 32'h8888_8813, 64'h8000_0100, 1'b1);
      cyc();
      cyc();
      check("resume_next_addr", ireq_addr, 64'h8000_0104);

      // PC wrap at the top of the address space
      iresp_data_ok = 1'b1; iresp_data = 32'h9999_9913;
      redirect_valid = 1'b1; redirect_pc = 64'hFFFF_FFFF_FFFF_FFFC;
      cyc();
      serve(1, 32'hAAAA_AA13, 64'hFFFF_FFFF_FFFF_FFFC, 1'b1);
      cyc();
      cyc();
      check("wrap_addr", ireq_addr, 64'h0);

      // Second redirect in DISCARD coincident with data_ok: newest wins
      redirect_valid = 1'b1; redirect_pc = 64'h8000_4000;
      cyc();
      check("disc2_old_addr", ireq_addr, 64'h0);
      redirect_valid = 1'b1; redirect_pc = 64'h8000_5000;
      iresp_data_ok = 1'b1; iresp_data = 32'hBBBB_BB13;
      cyc();
      serve(1, 32'hCCCC_CC13, 64'h8000_5000, 1'b1);
      cyc();
      cyc();
      check("disc2_next_addr", ireq_addr, 64'h8000_5004);

      // Reset in the middle of a request aborts at once
      check("queue_drained", 64'(exp_q.size()), 64'd0);
      reset_n = 1'b0;
      settle();
      check("midrst_no_req", {63'd0, ireq_valid}, 64'd0);
      check("midrst_out_pc", out_pc, 64'd0);
      check("midrst_out_instr", {32'd0, out_instr}, 64'd0);
      cyc();
      reset_n = 1'b1;
      settle();
      check("midrst_req_valid", {63'd0, ireq_valid}, 64'd1);
      check("midrst_req_addr", ireq_addr, RST_PC);
      repeat (3) cyc();
      check("final_no_out", {63'd0, out_valid}, 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
